otter_hazard_unit: RTL and testbench

Parametrised hazard controller for the pipelined OTTER. It replaces the hard-wired `PC_WRITE=1` and the fixed two-source forwarding mux selects. It generates:
- forwarding selects for N later stages;
- load-use stalls;
- branch/jump redirect flushes lasting a configurable number of cycles, covering synchronous-read instruction memory;
- whole-pipeline freeze for multi-cycle memory;
- saturating performance counters.

It sits beside the IF/ID/EX/MEM/WB registers and drives their write/flush enables.

---
 rtl/otter_pipe_pkg.sv | 13 +
 rtl/otter_sat_counter.sv | 33 +++
 rtl/otter_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_otter_hazard_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline control logic.
// Hazard FSM states, forwarding-select encoding and the zero register.
package otter_pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hz_state_t;

  localparam int         FWD_NONE = 0;
  localparam logic [4:0] REG_X0   = 5'd0;

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: CLK, RESET_N (async low), CLR, INC, Q[W-1:0].
module otter_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR)
      cnt_d = '0;
    else if (INC && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign Q = cnt_q;

endmodule

// File: rtl/otter_hazard_unit.sv
// OTTER hazard unit: forwarding selects, load-use stall, redirect squash,
// memory freeze and saturating perf counters; outputs are combinational.
module otter_hazard_unit
  import otter_pipe_pkg::*;
#(
  parameter int FWD_STAGES  = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32,
  parameter int SEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [4:0]              ID_RS1,
  input  logic [4:0]              ID_RS2,
  input  logic                    ID_RS1_USED,
  input  logic                    ID_RS2_USED,
  input  logic [4:0]              EX_RS1,
  input  logic [4:0]              EX_RS2,
  input  logic                    EX_RS1_USED,
  input  logic                    EX_RS2_USED,
  input  logic [4:0]              EX_RD,
  input  logic                    EX_REGWRITE,
  input  logic                    EX_MEMREAD,
  input  logic [5*FWD_STAGES-1:0] FWD_RD,
  input  logic [FWD_STAGES-1:0]   FWD_REGWRITE,
  input  logic                    REDIRECT,
  input  logic                    MEM_BUSY,
  input  logic                    CNT_CLR,
  output logic [SEL_W-1:0]        SEL_A,
  output logic [SEL_W-1:0]        SEL_B,
  output logic                    PC_WRITE,
  output logic                    IF_ID_WRITE,
  output logic                    IF_ID_FLUSH,
  output logic                    ID_EX_FLUSH,
  output logic                    PIPE_HOLD,
  output logic [CNT_W-1:0]        STALL_CNT,
  output logic [CNT_W-1:0]        LOADUSE_CNT,
  output logic [CNT_W-1:0]        FLUSH_CNT
);

  localparam logic [2:0] RELOAD = 3'(FLUSH_DEPTH - 1);

  logic [FWD_STAGES-1:0] hit_a;
  logic [FWD_STAGES-1:0] hit_b;

  for (genvar k = 0; k < FWD_STAGES; k++) begin : g_fwd
    logic [4:0] rd_k;
    assign rd_k = FWD_RD[5*k +: 5];
    assign hit_a[k] = EX_RS1_USED && FWD_REGWRITE[k] &&
                      (rd_k == EX_RS1) && (EX_RS1 != REG_X0);
    assign hit_b[k] = EX_RS2_USED && FWD_REGWRITE[k] &&
                      (rd_k == EX_RS2) && (EX_RS2 != REG_X0);
  end

  // Walk oldest to youngest so the youngest hit is written last.
  always_comb begin
    SEL_A = SEL_W'(FWD_NONE);
    SEL_B = SEL_W'(FWD_NONE);
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hit_a[k]) SEL_A = SEL_W'(k + 1);
      if (hit_b[k]) SEL_B = SEL_W'(k + 1);
    end
  end

  logic lu;
  assign lu = EX_MEMREAD && EX_REGWRITE && (EX_RD != REG_X0) &&
              ((ID_RS1_USED && (ID_RS1 == EX_RD)) ||
               (ID_RS2_USED && (ID_RS2 == EX_RD)));

  hz_state_t  state_q;
  hz_state_t  state_d;
  logic [2:0] fcnt_q;
  logic [2:0] fcnt_d;
  logic       lu_take;
  logic       redir_take;

  always_comb begin
    PC_WRITE    = 1'b1;
    IF_ID_WRITE = 1'b1;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    PIPE_HOLD   = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    lu_take     = 1'b0;
    redir_take  = 1'b0;
    priority case (1'b1)
      MEM_BUSY: begin
        PIPE_HOLD   = 1'b1;
        PC_WRITE    = 1'b0;
        IF_ID_WRITE = 1'b0;
      end
      REDIRECT: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        redir_take  = 1'b1;
        fcnt_d      = RELOAD;
        state_d     = (RELOAD != 3'd0) ? SQUASH : RUN;
      end
      (state_q == SQUASH): begin
        IF_ID_FLUSH = 1'b1;
        fcnt_d      = fcnt_q - 3'd1;
        state_d     = (fcnt_q == 3'd1) ? RUN : SQUASH;
      end
      lu: begin
        PC_WRITE    = 1'b0;
        IF_ID_WRITE = 1'b0;
        ID_EX_FLUSH = 1'b1;
        lu_take     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  otter_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLR     (CNT_CLR),
    .INC     (MEM_BUSY),
    .Q       (STALL_CNT)
  );

  otter_sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLR     (CNT_CLR),
    .INC     (lu_take),
    .Q       (LOADUSE_CNT)
  );

  otter_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLR     (CNT_CLR),
    .INC     (redir_take),
    .Q       (FLUSH_CNT)
  );

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Self-checking bench for otter_hazard_unit: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_otter_hazard_unit;

  localparam int NS = 3;
  localparam int FD = 2;
  localparam int CW = 4;
  localparam int SW = $clog2(NS + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic          id_u1, id_u2, ex_u1, ex_u2;
  logic          ex_rw, ex_mr;
  logic [5*NS-1:0] fwd_rd;
  logic [NS-1:0] fwd_we;
  logic          redirect, mem_busy, cnt_clr;
  logic [SW-1:0] sel_a, sel_b;
  logic          pc_we, ifid_we, ifid_fl, idex_fl, hold;
  logic [CW-1:0] stall_cnt, lu_cnt, fl_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  otter_hazard_unit #(
    .FWD_STAGES  (NS),
    .FLUSH_DEPTH (FD),
    .CNT_W       (CW)
  ) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .ID_RS1       (id_rs1),
    .ID_RS2       (id_rs2),
    .ID_RS1_USED  (id_u1),
    .ID_RS2_USED  (id_u2),
    .EX_RS1       (ex_rs1),
    .EX_RS2       (ex_rs2),
    .EX_RS1_USED  (ex_u1),
    .EX_RS2_USED  (ex_u2),
    .EX_RD        (ex_rd),
    .EX_REGWRITE  (ex_rw),
    .EX_MEMREAD   (ex_mr),
    .FWD_RD       (fwd_rd),
    .FWD_REGWRITE (fwd_we),
    .REDIRECT     (redirect),
    .MEM_BUSY     (mem_busy),
    .CNT_CLR      (cnt_clr),
    .SEL_A        (sel_a),
    .SEL_B        (sel_b),
    .PC_WRITE     (pc_we),
    .IF_ID_WRITE  (ifid_we),
    .IF_ID_FLUSH  (ifid_fl),
    .ID_EX_FLUSH  (idex_fl),
    .PIPE_HOLD    (hold),
    .STALL_CNT    (stall_cnt),
    .LOADUSE_CNT  (lu_cnt),
    .FLUSH_CNT    (fl_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    id_u1 = 0; id_u2 = 0; ex_u1 = 0; ex_u2 = 0;
    ex_rw = 0; ex_mr = 0; fwd_rd = '0; fwd_we = '0;
    redirect = 0; mem_busy = 0; cnt_clr = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    idle();
    cnt_clr = 1;
    adv();
    cnt_clr = 0;
  endtask

  task automatic set_lu();
    ex_mr = 1; ex_rw = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_u2 = 1;
  endtask

  typedef struct {
    logic [4:0]      r1, r2;
    logic            u1, u2;
    logic [5*NS-1:0] frd;
    logic [NS-1:0]   fwe;
    logic [4:0]      erd;
    logic            mr, rw;
    logic [4:0]      i1, i2;
    logic            iu1, iu2;
    logic [SW-1:0]   ea, eb;
    logic            epc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic [4:0] r1, r2, input logic u1, u2,
    input logic [5*NS-1:0] frd, input logic [NS-1:0] fwe,
    input logic [4:0] erd, input logic mr, rw,
    input logic [4:0] i1, i2, input logic iu1, iu2,
    input logic [SW-1:0] ea, eb, input logic epc);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.frd = frd; v.fwe = fwe; v.erd = erd; v.mr = mr; v.rw = rw;
    v.i1 = i1; v.i2 = i2; v.iu1 = iu1; v.iu2 = iu2;
    v.ea = ea; v.eb = eb; v.epc = epc;
    return v;
  endfunction

  // Reference: youngest stage whose write matches a nonzero used source.
  function automatic int fsel(input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 0;
    for (int k = 0; k < NS; k++)
      if (fwd_we[k] && fwd_rd[5*k +: 5] == rs) return k + 1;
    return 0;
  endfunction

  int m_sq, m_st, m_lu, m_fl;

  initial begin
    logic [14:0] f595;
    logic [14:0] f000;
    f595 = {5'd5, 5'd9, 5'd5};
    f000 = '0;
    idle();
    #1 rst_n = 0;
    #2;
    chk("rst_pc_write", pc_we, 1);
    chk("rst_ifid_write", ifid_we, 1);
    chk("rst_sel", {sel_a, sel_b}, 0);
    chk("rst_flush_hold", {ifid_fl, idex_fl, hold}, 0);
    chk("rst_counters", {stall_cnt, lu_cnt, fl_cnt}, 0);
    @(negedge clk);
    rst_n = 1;
    adv();

    tv.push_back(mk(5, 0, 1, 0, f595, 3'b111, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk(5, 0, 1, 0, f595, 3'b110, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, f000, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(5, 0, 0, 0, f595, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(5, 9, 1, 1, f595, 3'b111, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1));
    tv.push_back(mk(5, 9, 1, 1, f595, 3'b101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, f000, 3'b000, 7, 1, 1, 0, 7, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, f000, 3'b000, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, f000, 3'b000, 7, 1, 0, 7, 0, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, f000, 3'b000, 7, 1, 1, 7, 3, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, f000, 3'b000, 12, 1, 1, 12, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 1, f000, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (tv[i]) begin
      idle();
      ex_rs1 = tv[i].r1; ex_rs2 = tv[i].r2;
      ex_u1 = tv[i].u1; ex_u2 = tv[i].u2;
      fwd_rd = tv[i].frd; fwd_we = tv[i].fwe;
      ex_rd = tv[i].erd; ex_mr = tv[i].mr; ex_rw = tv[i].rw;
      id_rs1 = tv[i].i1; id_rs2 = tv[i].i2;
      id_u1 = tv[i].iu1; id_u2 = tv[i].iu2;
      @(negedge clk);
      chk($sformatf("vec%0d_sel_a", i), sel_a, tv[i].ea);
      chk($sformatf("vec%0d_sel_b", i), sel_b, tv[i].eb);
      chk($sformatf("vec%0d_pc_write", i), pc_we, tv[i].epc);
      chk($sformatf("vec%0d_idex_flush", i), idex_fl, !tv[i].epc);
      adv();
    end

    // Load-use: one bubble, then the load has left EX.
    clr_cnt();
    set_lu();
    @(negedge clk);
    chk("lu_pc_write", pc_we, 0);
    chk("lu_ifid_write", ifid_we, 0);
    chk("lu_idex_flush", idex_fl, 1);
    adv();
    idle();
    @(negedge clk);
    chk("lu_after_pc_write", pc_we, 1);
    chk("lu_after_idex_flush", idex_fl, 0);
    chk("lu_cnt", lu_cnt, 1);
    adv();

    // Redirect, then a second redirect once back in RUN.
    clr_cnt();
    redirect = 1;
    @(negedge clk);
    chk("rd_c0_flushes", {pc_we, ifid_fl, idex_fl}, 3'b111);
    adv();
    redirect = 0;
    @(negedge clk);
    chk("rd_c1_ifid_flush", ifid_fl, 1);
    chk("rd_c1_idex_flush", idex_fl, 0);
    chk("rd_c1_pc_write", pc_we, 1);
    chk("rd_c1_flush_cnt", fl_cnt, 1);
    adv();
    redirect = 1;
    @(negedge clk);
    chk("rd_c2_ifid_flush", ifid_fl, 1);
    adv();
    redirect = 0;
    @(negedge clk);
    chk("rd_c3_ifid_flush", ifid_fl, 1);
    adv();
    @(negedge clk);
    chk("rd_c4_ifid_flush", ifid_fl, 0);
    chk("rd_c4_flush_cnt", fl_cnt, 2);
    adv();

    // Redirect during squash reloads; load-use is ignored while squashing.
    clr_cnt();
    redirect = 1;
    adv();
    @(negedge clk);
    chk("reload_idex_flush", idex_fl, 1);
    adv();
    redirect = 0;
    set_lu();
    @(negedge clk);
    chk("sq_lu_ifid_flush", ifid_fl, 1);
    chk("sq_lu_pc_write", pc_we, 1);
    chk("sq_lu_idex_flush", idex_fl, 0);
    adv();
    idle();
    @(negedge clk);
    chk("reload_end_flush", ifid_fl, 0);
    chk("reload_flush_cnt", fl_cnt, 2);
    chk("reload_lu_cnt", lu_cnt, 0);
    adv();

    // MEM_BUSY holds a pending redirect.
    clr_cnt();
    mem_busy = 1;
    redirect = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("busy%0d_hold", c), hold, 1);
      chk($sformatf("busy%0d_pc_ifid", c), {pc_we, ifid_we, ifid_fl, idex_fl}, 0);
      adv();
    end
    mem_busy = 0;
    @(negedge clk);
    chk("busy_after_hold", hold, 0);
    chk("busy_after_flush", {ifid_fl, idex_fl}, 2'b11);
    chk("busy_stall_cnt", stall_cnt, 3);
    chk("busy_flush_cnt0", fl_cnt, 0);
    adv();
    redirect = 0;
    @(negedge clk);
    chk("busy_sq_flush", ifid_fl, 1);
    chk("busy_flush_cnt1", fl_cnt, 1);
    adv();

    // Busy during squash freezes the remaining squash count.
    clr_cnt();
    redirect = 1;
    adv();
    redirect = 0;
    mem_busy = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("sqbusy%0d_flush", c), ifid_fl, 0);
      adv();
    end
    mem_busy = 0;
    @(negedge clk);
    chk("sqbusy_resume_flush", ifid_fl, 1);
    adv();
    @(negedge clk);
    chk("sqbusy_done_flush", ifid_fl, 0);
    adv();

    // Saturation and clear-over-increment.
    clr_cnt();
    mem_busy = 1;
    repeat (20) adv();
    mem_busy = 0;
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, CMAX);
    adv();
    mem_busy = 1;
    cnt_clr = 1;
    adv();
    idle();
    @(negedge clk);
    chk("clr_over_inc", stall_cnt, 0);
    adv();

    // Asynchronous reset in the middle of a squash.
    redirect = 1;
    adv();
    redirect = 0;
    #1;
    chk("pre_rst_squash", ifid_fl, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_flush", ifid_fl, 0);
    chk("mid_rst_pc_write", pc_we, 1);
    chk("mid_rst_counters", {stall_cnt, lu_cnt, fl_cnt}, 0);
    @(negedge clk);
    rst_n = 1;
    adv();
    @(negedge clk);
    chk("post_rst_flush", ifid_fl, 0);
    chk("post_rst_pc_write", pc_we, 1);
    adv();

    // Randomized run from a just-reset unit.
    m_sq = 0; m_st = 0; m_lu = 0; m_fl = 0;
    for (int n = 0; n < 400; n++) begin
      bit lu, lu_inc, care_w;
      int e_pc, e_ifw, e_iff, e_ief, e_hold;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3));
      ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_u1 = 1'($urandom); id_u2 = 1'($urandom);
      ex_u1 = 1'($urandom); ex_u2 = 1'($urandom);
      ex_rw = 1'($urandom); ex_mr = 1'($urandom);
      for (int k = 0; k < NS; k++)
        fwd_rd[5*k +: 5] = 5'($urandom_range(0, 3));
      fwd_we = NS'($urandom);
      redirect = ($urandom_range(0, 99) < 15);
      mem_busy = ($urandom_range(0, 99) < 15);
      cnt_clr  = ($urandom_range(0, 99) < 3);

      lu = ex_mr && ex_rw && ex_rd != 0 &&
           ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
      care_w = 1; lu_inc = 0;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_ief = 0; e_hold = 0;
      if (mem_busy) begin
        e_pc = 0; e_ifw = 0; e_hold = 1;
      end else if (redirect) begin
        e_iff = 1; e_ief = 1; care_w = 0;
      end else if (m_sq > 0) begin
        e_iff = 1; care_w = 0;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_ief = 1; lu_inc = 1;
      end

      @(negedge clk);
      chk("rnd_sel_a", sel_a, fsel(ex_rs1, ex_u1));
      chk("rnd_sel_b", sel_b, fsel(ex_rs2, ex_u2));
      chk("rnd_pc_write", pc_we, e_pc);
      chk("rnd_ifid_flush", ifid_fl, e_iff);
      chk("rnd_idex_flush", idex_fl, e_ief);
      chk("rnd_hold", hold, e_hold);
      if (care_w) chk("rnd_ifid_write", ifid_we, e_ifw);
      chk("rnd_stall_cnt", stall_cnt, m_st);
      chk("rnd_lu_cnt", lu_cnt, m_lu);
      chk("rnd_flush_cnt", fl_cnt, m_fl);
      adv();

      if (cnt_clr) begin
        m_st = 0; m_lu = 0; m_fl = 0;
      end else begin
        if (mem_busy && m_st < CMAX) m_st++;
        if (lu_inc && m_lu < CMAX) m_lu++;
        if (!mem_busy && redirect && m_fl < CMAX) m_fl++;
      end
      if (!mem_busy) begin
        if (redirect) m_sq = FD - 1;
        else if (m_sq > 0) m_sq--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
